// File: rtl/sn74ls191.sv
// sn74ls191 -- synchronous 4-bit up/down counter with parallel load.
//
// Parameters:
//   MODULUS  count modulus, 2..16 (16 = plain binary counter)
//
// Ports:
//   clk      single clock, all state changes on the rising edge
//   clr_n    asynchronous active-low clear
//   load_n   synchronous active-low parallel load (overrides counting)
//   cten_n   active-low count enable
//   down     count direction: 0 = up, 1 = down
//   d        parallel load data, d[0] = A ... d[3] = D
//   q        counter state, q[0] = QA ... q[3] = QD
//   max_min  terminal-count decode (max when counting up, zero when down)
//   rco_n    active-low ripple clock, low during the clk-low phase of an
//            enabled terminal-count cycle
module sn74ls191 #(
  parameter int unsigned MODULUS = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       load_n,
  input  logic       cten_n,
  input  logic       down,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       max_min,
  output logic       rco_n
);

  localparam logic [3:0] TOP = 4'(MODULUS - 1);

  // Loaded values may sit above TOP; counting up from there wraps to 0,
  // hence the >= comparison rather than equality.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (!load_n) begin
      q <= d;
    end else if (!cten_n) begin
      if (!down) begin
        q <= (q >= TOP) ? '0 : q + 4'd1;
      end else begin
        q <= (q == '0) ? TOP : q - 4'd1;
      end
    end
  end

  always_comb begin
    max_min = down ? (q == '0) : (q >= TOP);
  end

  // Gated by the clock level so a cascaded stage sees one low pulse that
  // ends on the same rising edge that wraps this stage.
  always_comb begin
    rco_n = ~(max_min & ~cten_n & load_n & ~clk);
  end

endmodule

// File: tb/tb_sn74ls191.sv
// tb_sn74ls191 -- directed self-checking bench for sn74ls191.
// Two instances share all inputs: MODULUS = 16 and MODULUS = 12.
module tb_sn74ls191;

  logic       clk;
  logic       clr_n;
  logic       load_n;
  logic       cten_n;
  logic       down;
  logic [3:0] d;

  logic [3:0] q16;
  logic       mm16;
  logic       rco16;
  logic [3:0] q12;
  logic       mm12;
  logic       rco12;

  int checks   = 0;
  int failures = 0;
  int rco_lows = 0;

  sn74ls191 #(.MODULUS(16)) u16 (
    .clk     (clk),
    .clr_n   (clr_n),
    .load_n  (load_n),
    .cten_n  (cten_n),
    .down    (down),
    .d       (d),
    .q       (q16),
    .max_min (mm16),
    .rco_n   (rco16)
  );

  sn74ls191 #(.MODULUS(12)) u12 (
    .clk     (clk),
    .clr_n   (clr_n),
    .load_n  (load_n),
    .cten_n  (cten_n),
    .down    (down),
    .d       (d),
    .q       (q12),
    .max_min (mm12),
    .rco_n   (rco12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge (clk high).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample 1 time unit after the falling edge (clk low).
  task automatic low_phase();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_q;
    logic [3:0] seq12 [5];
    logic [3:0] seq33 [4];

    clr_n  = 1'b0;
    load_n = 1'b1;
    cten_n = 1'b1;
    down   = 1'b0;
    d      = 4'd0;
    #2;

    // Reset state and max_min during reset
    chk("rst_q16", q16, 4'd0);
    chk("rst_q12", q12, 4'd0);
    chk("rst_mm_up", mm16, 1'b0);
    down = 1'b1;
    #1;
    chk("rst_mm_down", mm16, 1'b1);
    down = 1'b0;

    // Clear dominates load and count across clock edges
    load_n = 1'b0;
    cten_n = 1'b0;
    d      = 4'd5;
    tick();
    tick();
    chk("rst_hold_q16", q16, 4'd0);
    load_n = 1'b1;
    clr_n  = 1'b1;

    // Up count through wrap, MODULUS 16
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_q = i % 16;
      chk("up16_q", q16, 4'(exp_q));
      chk("up16_mm", mm16, (exp_q == 15) ? 1'b1 : 1'b0);
      chk("up16_rco_hi", rco16, 1'b1);
      low_phase();
      chk("up16_rco_lo", rco16, (exp_q == 15) ? 1'b0 : 1'b1);
      if (rco16 == 1'b0) rco_lows++;
    end
    chk("up16_rco_pulses", 4'(rco_lows), 4'd1);

    // Load beats count; then hold
    tick();
    load_n = 1'b0;
    cten_n = 1'b0;
    d      = 4'd9;
    tick();
    chk("load9_q16", q16, 4'd9);
    chk("load9_q12", q12, 4'd9);
    load_n = 1'b1;
    cten_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q16", q16, 4'd9);
    end

    // MODULUS 12 down count through wrap
    load_n = 1'b0;
    d      = 4'd3;
    down   = 1'b1;
    tick();
    chk("load3_q12", q12, 4'd3);
    load_n = 1'b0;
    load_n = 1'b1;
    cten_n = 1'b0;
    seq12[0] = 4'd2; seq12[1] = 4'd1; seq12[2] = 4'd0;
    seq12[3] = 4'd11; seq12[4] = 4'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dn12_q", q12, seq12[i]);
      chk("dn12_mm", mm12, (seq12[i] == 4'd0) ? 1'b1 : 1'b0);
      low_phase();
      chk("dn12_rco", rco12, (seq12[i] == 4'd0) ? 1'b0 : 1'b1);
    end

    // MODULUS 12 load above range, count up wraps to 0
    tick();
    load_n = 1'b0;
    d      = 4'd14;
    down   = 1'b0;
    tick();
    chk("load14_q12", q12, 4'd14);
    chk("load14_mm12", mm12, 1'b1);
    chk("load14_mm16", mm16, 1'b0);
    load_n = 1'b1;
    tick();
    chk("ov12_q0", q12, 4'd0);
    chk("ov16_q15", q16, 4'd15);
    tick();
    chk("ov12_q1", q12, 4'd1);
    chk("ov16_q0", q16, 4'd0);

    // Direction toggling on alternate edges, MODULUS 16
    load_n = 1'b0;
    d      = 4'd5;
    tick();
    chk("load5_q16", q16, 4'd5);
    load_n = 1'b1;
    seq33[0] = 4'd6; seq33[1] = 4'd5; seq33[2] = 4'd6; seq33[3] = 4'd5;
    for (int i = 0; i < 4; i++) begin
      down = (i % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      chk("dir_q16", q16, seq33[i]);
    end

    // max_min and rco_n follow direction / enable combinationally
    cten_n = 1'b1;
    load_n = 1'b0;
    d      = 4'd0;
    down   = 1'b0;
    tick();
    load_n = 1'b1;
    chk("mm0_up", mm16, 1'b0);
    down = 1'b1;
    #1;
    chk("mm0_down", mm16, 1'b1);
    load_n = 1'b0;
    d      = 4'd15;
    tick();
    load_n = 1'b1;
    chk("mm15_down", mm16, 1'b0);
    down = 1'b0;
    #1;
    chk("mm15_up", mm16, 1'b1);
    low_phase();
    chk("rco_disabled", rco16, 1'b1);
    cten_n = 1'b0;
    #1;
    chk("rco_enabled", rco16, 1'b0);
    load_n = 1'b0;
    #1;
    chk("rco_loading", rco16, 1'b1);

    // Asynchronous clear mid-count
    d = 4'd4;
    tick();
    chk("load4_q16", q16, 4'd4);
    load_n = 1'b1;
    cten_n = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      tick();
      chk("pre_clr_q16", q16, 4'(i));
    end
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_clr_q16", q16, 4'd0);
    chk("async_clr_q12", q12, 4'd0);
    tick();
    chk("clr_held_q16", q16, 4'd0);
    clr_n = 1'b1;
    tick();
    chk("post_clr_q16", q16, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
